prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader: the write side of the core's instruction memory. It receives a framed byte stream, assembles little-endian 32-bit words and writes them sequentially from address 0 into the instruction RAM. It holds the core in reset and disabled while loading, then releases it to fetch from PC = 0. It also supports reload on request.

## Interface
Parameters:
- ADDR_W, 9, byte-address width of instruction memory, matching the core's PC width; capacity MAX_WORDS = 2^(ADDR_W-2) = 128.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- byte_i  in  8  incoming stream byte
- byte_valid_i  in  1  byte_i holds a byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- reload_i  in  1  request a new load; honoured in RUN or ERR only
- mem_we_o  out  1  instruction-memory write strobe
- mem_addr_o  out  ADDR_W  write byte address, always word aligned
- mem_wdata_o  out  32  write data
- core_rst_o  out  1  drives core rst_i
- core_en_o  out  1  drives core en_i
- err_o  out  1  frame rejected

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes, each word little-endian (first byte goes to [7:0]). With LOADER_CHECKSUM_EN defined, one trailing checksum byte follows the data.
- States:
  - LEN0 (reset state): accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI.
    - If N > MAX_WORDS → ERR.
    - Else if N == 0 → CSUM (macro on) or RUN.
    - Else → DATA.
  - DATA: accept bytes into byte lane 0..3; the 4th byte → WRITE.
  - WRITE: one cycle. Issue the write.
    - If words written == N → CSUM or RUN.
    - Else → DATA.
  - CSUM: accept one byte.
    - If it equals the running XOR → RUN.
    - Else → ERR.
  - RUN: core_rst_o = 0, core_en_o = 1.
  - ERR: err_o = 1; core stays held.
- A byte transfers on valid & ready. byte_ready_o = 1 in LEN0, LEN1, DATA and CSUM; 0 otherwise.
- Word index counter has ADDR_W-2 bits; mem_addr_o = {index, 2'b00}. The index never wraps, because N ≤ MAX_WORDS is enforced before DATA. N = 128 writes addresses 0..508.
- core_rst_o = 1 and core_en_o = 0 in every state except RUN.
- reload_i in RUN or ERR:
  - Next state LEN0.
  - Clears err_o, the word index, the byte lane and the XOR accumulator.
  - Core is re-held on the following cycle.
- reload_i is ignored in all other states.
- byte_valid_i in WRITE, RUN or ERR is not accepted; the byte is not consumed.
- Instruction memory contents beyond word N-1 are left untouched.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Reset values: state LEN0; byte_ready_o 1 (LEN0 decode); mem_we_o 0; mem_addr_o 0; mem_wdata_o 0; core_rst_o 1; core_en_o 0; err_o 0.
- Write latency: mem_we_o is high for exactly the one cycle after the 4th byte of a word is accepted. Address and data are stable in that cycle.
- Back-to-back stream: 4 bytes, then 1 WRITE bubble, per word. Total load time = 2 + 5·N (+1 with checksum) cycles at full rate.
- core_en_o rises on the cycle after the transition into RUN; core_rst_o falls in the same cycle.
- Async reset mid-load aborts immediately: state LEN0, outputs at reset values, partial word discarded.

## Configuration
- LOADER_CHECKSUM_EN
  - Defined: an 8-bit XOR accumulator covers LEN_LO, LEN_HI and all data bytes. The CSUM state checks the trailing byte; a mismatch gives ERR.
  - Undefined: no CSUM state and no accumulator. The last WRITE (or LEN1 with N == 0) goes directly to RUN. err_o can then only be caused by oversize N.

## Structure
- loader_pkg:
  - state enum loader_state_e (LEN0, LEN1, DATA, WRITE, CSUM, RUN, ERR);
  - DEFAULT_ADDR_W = 9;
  - LEN_W = 16.
- One sub-module, loader_word_asm:
  - 2-bit byte-lane counter plus a 32-bit shift/assembly register;
  - outputs word_done and word[31:0];
  - lane counter is cleared by the parent on reload.

## Test plan
- N = 2, bytes 02 00 | 13 00 00 00 | 6F 00 00 00 → writes 0x00000013 @0, then 0x0000006F @4. core_en_o = 1 after 2 + 10 cycles.
- N = 0 (00 00) → no mem_we_o, straight to RUN. With the macro on, checksum byte 00 is required.
- N = 129 (81 00) → ERR, err_o = 1, byte_ready_o = 0, core_rst_o stays 1. Then reload_i, then a valid frame → RUN with err_o = 0.
- Macro on, N = 1, data AA BB CC DD:
  - checksum 01^00^AA^BB^CC^DD = 01 → RUN;
  - checksum 02 → ERR.
- byte_valid_i toggled randomly during load → identical writes. No byte is lost or duplicated, including bytes offered during WRITE.
- rst_i pulsed after 3 data bytes → outputs at reset values. A new frame loads from address 0 with the correct first word.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional trailing-checksum support is selected with LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        RUN   = 3'd5,
        ERR   = 3'd6
    } loader_state_e;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int LEN_W          = 16;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: collects four bytes into a 32-bit word.
// word_done flags the byte that completes a word; word holds it afterwards.
module loader_word_asm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [31:0] word_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else if (clr_i) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_en_i) begin
            word_q[{lane_q, 3'b000} +: 8] <= byte_i;
            lane_q                        <= lane_q + 2'd1;
        end
    end

    assign word_done = byte_en_i && (lane_q == 2'd3);
    assign word      = word_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: framed byte stream -> sequential instruction-RAM writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state | meaning
// LEN0  | wait for word-count low byte
// LEN1  | wait for word-count high byte, range check
// DATA  | collecting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CSUM  | wait for checksum byte (LOADER_CHECKSUM_EN only)
// RUN   | core released
// ERR   | frame rejected, core held
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              reload_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_o,
    output logic              core_en_o,
    output logic              err_o
);

    localparam int IDX_W     = ADDR_W - 2;
    localparam int MAX_WORDS = 2 ** IDX_W;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e DONE_ST = CSUM;
`else
    localparam loader_state_e DONE_ST = RUN;
`endif

    loader_state_e    state_q, state_d;
    logic [7:0]       len_lo_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] n_rx;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             reload_ok;
    logic             last_word;
    logic             word_done;
    logic [31:0]      word;

    assign accept    = byte_valid_i && byte_ready_o;
    assign reload_ok = reload_i && ((state_q == RUN) || (state_q == ERR));
    assign n_rx      = {byte_i, len_lo_q};
    assign last_word = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    loader_word_asm u_word_asm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (reload_ok),
        .byte_en_i (accept && (state_q == DATA)),
        .byte_i    (byte_i),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LEN0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xor_q <= 8'd0;
        end else if (reload_ok) begin
            xor_q <= 8'd0;
        end else if (accept && (state_q != CSUM)) begin
            xor_q <= xor_q ^ byte_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: if (accept) state_d = LEN1;
            LEN1: begin
                if (accept) begin
                    if (n_rx > LEN_W'(MAX_WORDS)) state_d = ERR;
                    else if (n_rx == '0)          state_d = DONE_ST;
                    else                          state_d = DATA;
                end
            end
            DATA:  if (word_done) state_d = WRITE;
            WRITE: state_d = last_word ? DONE_ST : DATA;
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) state_d = (byte_i == xor_q) ? RUN : ERR;
`else
                state_d = ERR;
`endif
            end
            RUN:     if (reload_i) state_d = LEN0;
            ERR:     if (reload_i) state_d = LEN0;
            default: state_d = LEN0;
        endcase
    end

    always_comb begin
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        core_rst_o   = 1'b1;
        core_en_o    = 1'b0;
        err_o        = 1'b0;
        case (state_q)
            LEN0, LEN1, DATA, CSUM: byte_ready_o = 1'b1;
            WRITE:                  mem_we_o     = 1'b1;
            RUN: begin
                core_rst_o = 1'b0;
                core_en_o  = 1'b1;
            end
            ERR:     err_o = 1'b1;
            default: ;
        endcase
    end

    // Index stays on the last word after the final write, so it cannot wrap at N = MAX_WORDS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_lo_q <= 8'd0;
            len_q    <= '0;
            idx_q    <= '0;
        end else begin
            if (accept && (state_q == LEN0)) len_lo_q <= byte_i;
            if (accept && (state_q == LEN1)) len_q    <= n_rx;
            if (reload_ok || (state_q == LEN0)) begin
                idx_q <= '0;
            end else if ((state_q == WRITE) && !last_word) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign mem_addr_o  = {idx_q, 2'b00};
    assign mem_wdata_o = word;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a frame-level reference model.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_prog_loader;

    localparam int ADDR_W = 9;
    localparam int MAXW   = 128;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [7:0]        byte_i = 8'd0;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              reload_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              core_rst_o;
    logic              core_en_o;
    logic              err_o;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc_cnt = 0;
    int unsigned start_cyc = 0;
    logic [7:0]  frame[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_err;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .reload_i     (reload_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_o   (core_rst_o),
        .core_en_o    (core_en_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("wr_addr", 32'(mem_addr_o), exp_addr.pop_front());
                chk("wr_data", mem_wdata_o, exp_data.pop_front());
            end
        end
    end

    // Frame semantics: count, little-endian words at 4*i, optional XOR over all preceding bytes.
    task automatic model_frame();
        int n;
        logic [7:0] x;
        n = int'({frame[1], frame[0]});
        exp_err = 1'b0;
        if (n > MAXW) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(32'(4 * i));
                exp_data.push_back({frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
            end
            if (CS == 1) begin
                x = 8'd0;
                for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame[i];
                exp_err = (frame[2+4*n] != x);
            end
        end
    endtask

    task automatic build_frame(input int n);
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    endtask

    task automatic add_csum();
        logic [7:0] x;
        x = 8'd0;
        foreach (frame[i]) x = x ^ frame[i];
        if (CS == 1) frame.push_back(x);
    endtask

    task automatic send_frame(input int nbytes, input bit full);
        int idx;
        int t;
        logic v;
        idx = 0;
        t = 0;
        while (idx < nbytes && t < 4000) begin
            @(negedge clk_i);
            if (idx == 0 && t == 0) start_cyc = cyc_cnt;
            v = full ? 1'b1 : 1'($urandom_range(0, 1));
            byte_valid_i = v;
            byte_i = v ? frame[idx] : 8'($urandom);
            if (v && byte_ready_o) idx++;
            t++;
        end
        if (idx < nbytes) chk("send_timeout", 32'(idx), 32'(nbytes));
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
    endtask

    task automatic check_outcome(input string tag, input bit full, input int n);
        int t;
        t = 0;
        while (!(core_en_o || err_o) && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!(core_en_o || err_o)) chk({tag, "_done_timeout"}, 32'd1, 32'd0);
        if (full) chk({tag, "_load_cycles"}, cyc_cnt - start_cyc, 32'(2 + 5 * n + CS));
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
        chk({tag, "_core_en"}, 32'(core_en_o), 32'(!exp_err));
        chk({tag, "_core_rst"}, 32'(core_rst_o), 32'(exp_err));
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        chk({tag, "_pending_wr"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bit full);
        int n;
        n = int'({frame[1], frame[0]});
        model_frame();
        send_frame(frame.size(), full);
        check_outcome(tag, full, n);
    endtask

    task automatic do_reload();
        @(negedge clk_i);
        reload_i = 1'b1;
        @(negedge clk_i);
        reload_i = 1'b0;
        chk("reload_core_rst", 32'(core_rst_o), 32'd1);
        chk("reload_core_en", 32'(core_en_o), 32'd0);
        chk("reload_err", 32'(err_o), 32'd0);
        chk("reload_ready", 32'(byte_ready_o), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd1);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_core_rst"}, 32'(core_rst_o), 32'd1);
        chk({tag, "_core_en"}, 32'(core_en_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    task automatic plan_frame();
        frame.delete();
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        add_csum();
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("rst");

        plan_frame();
        run_frame("n2", 1'b1);

        do_reload();
        build_frame(0);
        add_csum();
        run_frame("n0", 1'b1);

        do_reload();
        build_frame(129);
        frame = frame[0:1];
        run_frame("n129", 1'b0);
        repeat (3) @(negedge clk_i);
        chk("err_hold", 32'(err_o), 32'd1);
        do_reload();
        build_frame(3);
        add_csum();
        run_frame("after_err", 1'b0);

`ifdef LOADER_CHECKSUM_EN
        do_reload();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        run_frame("csum_ok", 1'b1);
        do_reload();
        frame = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};
        run_frame("csum_bad", 1'b0);
`endif

        for (int k = 0; k < 6; k++) begin
            do_reload();
            build_frame($urandom_range(1, 10));
            add_csum();
            run_frame("rand", 1'b0);
        end

        do_reload();
        build_frame(MAXW);
        add_csum();
        run_frame("n128", 1'b1);

        do_reload();
        plan_frame();
        send_frame(5, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        plan_frame();
        run_frame("post_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
